// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Core-wide constants and control-transfer kind encoding.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        CF_NONE   = 3'd0,
        CF_BRANCH = 3'd1,
        CF_JUMP   = 3'd2,
        CF_CALL   = 3'd3,
        CF_RET    = 3'd4
    } cf_kind_e;

endpackage
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_addr_stack
// Brief    : Circular return-address stack; a push onto a full stack
//            overwrites the oldest entry, and a pop of an empty stack is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    input  logic            clear,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]    r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_PTR_W-1:0] w_ptrInc;
    logic [c_PTR_W-1:0] w_ptrDec;

    // r_ptr is the next free slot; explicit wrap keeps non-trivial depths safe
    assign w_ptrInc = (r_ptr == c_PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign w_ptrDec = (r_ptr == '0) ? c_PTR_W'(RAS_DEPTH - 1) : r_ptr - 1'b1;

    assign top   = r_mem[w_ptrDec];
    assign empty = (r_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (push && !clear) begin
            r_mem[r_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_ptr <= w_ptrInc;
            if (r_cnt != c_CNT_W'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (pop && !empty) begin
            r_ptr <= w_ptrDec;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_ras.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_ras
// Brief    : Tagged direct-mapped BTB with 2-bit direction counters and a
//            non-speculative return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_ras
    import riscv_pkg::*;
#(
    parameter int         BTB_ENTRIES = 16,
    parameter int         TAG_BITS    = 8,
    parameter int         RAS_DEPTH   = 4,
    parameter logic [1:0] CTR_INIT    = 2'b10
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            fetch_hit_o,
    output logic [XLEN-1:0] fetch_target_o,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  cf_kind_e        ex_kind_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_compressed_i,
    input  logic            ex_mispredict_i,
    output logic [31:0]     mispredict_cnt_o
);

    localparam int c_IDX = $clog2(BTB_ENTRIES);

    logic                r_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]     r_target [BTB_ENTRIES];
    cf_kind_e            r_kind   [BTB_ENTRIES];
    logic [1:0]          r_ctr    [BTB_ENTRIES];
    logic [31:0]         r_mispredictCnt;

    logic [c_IDX-1:0]    w_fIdx;
    logic [TAG_BITS-1:0] w_fTag;
    logic                w_fMatch;
    logic [c_IDX-1:0]    w_eIdx;
    logic [TAG_BITS-1:0] w_eTag;
    logic                w_eMatch;
    logic                w_update;
    logic                w_isBranch;
    logic                w_rasPush;
    logic                w_rasPop;
    logic [XLEN-1:0]     w_rasPushData;
    logic [XLEN-1:0]     w_rasTop;
    logic                w_rasEmpty;
    logic                w_unused;

    // Halfword-granular indexing so compressed instructions get their own slot
    assign w_fIdx = fetch_pc_i[c_IDX:1];
    assign w_fTag = fetch_pc_i[c_IDX+TAG_BITS:c_IDX+1];
    assign w_eIdx = ex_pc_i[c_IDX:1];
    assign w_eTag = ex_pc_i[c_IDX+TAG_BITS:c_IDX+1];

    assign w_fMatch   = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
    assign w_eMatch   = r_valid[w_eIdx] && (r_tag[w_eIdx] == w_eTag);
    assign w_update   = ex_valid_i && (ex_kind_i != CF_NONE);
    assign w_isBranch = (ex_kind_i == CF_BRANCH);

    always_comb begin
        fetch_hit_o    = w_fMatch && ((r_kind[w_fIdx] != CF_BRANCH) || r_ctr[w_fIdx][1]);
        fetch_target_o = '0;
        if (fetch_hit_o) begin
            if ((r_kind[w_fIdx] == CF_RET) && !w_rasEmpty) begin
                fetch_target_o = w_rasTop;
            end else begin
                fetch_target_o = r_target[w_fIdx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (clear_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_update) begin
            if (w_eMatch) begin
                if (w_isBranch) begin
                    if (ex_taken_i && (r_ctr[w_eIdx] != 2'b11)) begin
                        r_ctr[w_eIdx] <= r_ctr[w_eIdx] + 2'd1;
                    end else if (!ex_taken_i && (r_ctr[w_eIdx] != 2'b00)) begin
                        r_ctr[w_eIdx] <= r_ctr[w_eIdx] - 2'd1;
                    end
                end else begin
                    r_ctr[w_eIdx] <= 2'b11;
                end
            end else if (ex_taken_i) begin
                r_valid[w_eIdx] <= 1'b1;
                r_ctr[w_eIdx]   <= w_isBranch ? CTR_INIT : 2'b11;
            end
        end
    end

    // Payload fields need no reset: they are only observed behind a valid bit
    always_ff @(posedge clk_i) begin
        if (!clear_i && w_update) begin
            if (w_eMatch) begin
                if (!w_isBranch) begin
                    r_target[w_eIdx] <= ex_target_i;
                    r_kind[w_eIdx]   <= ex_kind_i;
                end else if (ex_taken_i) begin
                    r_target[w_eIdx] <= ex_target_i;
                end
            end else if (ex_taken_i) begin
                r_tag[w_eIdx]    <= w_eTag;
                r_target[w_eIdx] <= ex_target_i;
                r_kind[w_eIdx]   <= ex_kind_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mispredictCnt <= '0;
        end else if (ex_valid_i && ex_mispredict_i) begin
            r_mispredictCnt <= r_mispredictCnt + 32'd1;
        end
    end

    assign mispredict_cnt_o = r_mispredictCnt;

    assign w_rasPush     = ex_valid_i && (ex_kind_i == CF_CALL) && ex_taken_i;
    assign w_rasPop      = ex_valid_i && (ex_kind_i == CF_RET) && ex_taken_i;
    assign w_rasPushData = ex_pc_i + (ex_compressed_i ? XLEN'(2) : XLEN'(4));

    return_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (w_rasPush),
        .pop       (w_rasPop),
        .push_data (w_rasPushData),
        .clear     (clear_i),
        .top       (w_rasTop),
        .empty     (w_rasEmpty)
    );

    assign w_unused = ^{fetch_pc_i[0], fetch_pc_i[XLEN-1:c_IDX+TAG_BITS+1],
                        ex_pc_i[0], ex_pc_i[XLEN-1:c_IDX+TAG_BITS+1]};

endmodule
`default_nettype wire
